ram_dma: RTL and testbench
==========================

// Module: ram_dma
// PURPOSE
//  Bus-master engine driving the single-port synchronous RAM (1-cycle registered read,
//  active-high write enable, read-before-write on the same address). On a start request it
//  either copies LEN words from SRC to DST (COPY) or writes FILL_VALUE to LEN words at DST
//  (FILL). Sits beside the CPU and is muxed onto the RAM port while busy.
// PARAMETERS
//  ADDR_WIDTH  16              RAM address bits; all addresses wrap modulo 2**ADDR_WIDTH
//  DATA_WIDTH  16              RAM data bits
//  LEN_WIDTH   ADDR_WIDTH+1    transfer-length bits; allows copying the whole memory
// PORTS
//  clk         in   1           clock, all state on rising edge
//  reset_n     in   1           asynchronous, active-low reset
//  start       in   1           request; accepted on a rising edge while busy==0
//  mode        in   1           0=COPY, 1=FILL; sampled with start
//  src_addr    in   ADDR_WIDTH  COPY source base; sampled with start
//  dst_addr    in   ADDR_WIDTH  destination base; sampled with start
//  len         in   LEN_WIDTH   word count; sampled with start
//  fill_value  in   DATA_WIDTH  FILL data; sampled with start
//  busy        out  1           transfer in progress (states RD/WR)
//  done        out  1           one-cycle completion pulse
//  mem_addr    out  ADDR_WIDTH  RAM address
//  mem_din     out  DATA_WIDTH  RAM write data
//  mem_dout    in   DATA_WIDTH  RAM read data, valid the cycle after its address
//  mem_we      out  1           RAM write enable, active high
// BEHAVIOUR
//  - Reset (async): state=IDLE; busy, done, mem_we, mem_addr, mem_din all 0.
//  - Outputs decoded combinationally from registered state/counters; mem_we high only in WR.
//  - States: IDLE, RD, WR, DONE.
//    IDLE/DONE + start: latch inputs; len==0 -> DONE; COPY -> RD; FILL -> WR.
//    DONE without start -> IDLE. DONE lasts exactly one cycle (done=1, busy=0).
//    RD: mem_addr=src_ptr, mem_we=0 -> WR.
//    WR: mem_addr=dst_ptr, mem_we=1, mem_din = COPY ? mem_dout : fill_value;
//        src_ptr++, dst_ptr++, remaining--; remaining hits 0 -> DONE, else COPY->RD, FILL->WR.
//  - Throughput: COPY 2 cycles/word, FILL 1 cycle/word. Start edge to done pulse:
//    COPY 2*len+1 cycles, FILL len+1, len==0 one cycle (no RAM write).
//  - start while busy ignored; input changes after acceptance have no effect.
//  - Pointer increments wrap at 2**ADDR_WIDTH; remaining is unsigned, never underflows.
//  - Overlap: strict forward word-by-word semantics (each read sees prior writes); no memmove.
//  - Reset mid-transfer: mem_we drops immediately; partially written words stay written.
// STRUCTURE
//  - Shared include ram_dma_defs.vh: state encodings (IDLE/RD/WR/DONE), MODE_COPY/MODE_FILL.
//  - Single module; src/dst pointers and length counter inline. No sub-module.
//  - RAM instantiated only in the bench/top; engine has no memory of its own.
// TESTING
//  1. Assert reset_n=0 mid-run -> busy=0, done=0, mem_we=0, mem_addr=0, mem_din=0 at once.
//  2. COPY src=0x0010 dst=0x0100 len=3, RAM[0x10..0x12]=A,B,C -> done 7 cycles after start
//     edge; RAM[0x100..0x102]=A,B,C; mem_we high exactly 3 cycles, never in RD.
//  3. FILL dst=0xFFFE len=4 fill=0xBEEF -> writes 0xFFFE,0xFFFF,0x0000,0x0001 on 4
//     consecutive cycles; done 5 cycles after start.
//  4. len=0 (both modes) -> done pulse 1 cycle after start, mem_we never asserted, busy never 1.
//  5. start pulsed during COPY len=4 -> ignored, one done only; reset after 2nd write then
//     new FILL len=1 -> completes normally; RAM words 3-4 of aborted copy untouched.
//  6. Overlap COPY src=0x20 dst=0x21 len=3, RAM[0x20]=X -> RAM[0x21..0x23]=X,X,X.

Source files
------------

// File: rtl/ram_dma_pkg.sv
// ram_dma_pkg: shared state and mode encodings for the RAM DMA engine
package ram_dma_pkg;
  typedef enum logic [1:0] {IDLE, RD, WR, DONE} state_t;
  typedef enum logic {MODE_COPY = 1'b0, MODE_FILL = 1'b1} mode_t;
endpackage

// File: rtl/ram_dma_if.sv
// ram_dma_if: single-port synchronous RAM bus between the DMA engine and the RAM
interface ram_dma_if #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 16
);
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_din;
  logic [DATA_WIDTH-1:0] mem_dout;
  logic                  mem_we;
  modport master (output mem_addr, mem_din, mem_we, input mem_dout);
  modport slave  (input mem_addr, mem_din, mem_we, output mem_dout);
endinterface

// File: rtl/ram_dma.sv
// ram_dma: COPY/FILL bus-master engine for a single-port synchronous RAM
module ram_dma
  import ram_dma_pkg::*;
#(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 16,
  parameter int LEN_WIDTH  = ADDR_WIDTH + 1
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic                  mode,
  input  logic [ADDR_WIDTH-1:0] src_addr,
  input  logic [ADDR_WIDTH-1:0] dst_addr,
  input  logic [LEN_WIDTH-1:0]  len,
  input  logic [DATA_WIDTH-1:0] fill_value,
  output logic                  busy,
  output logic                  done,
  ram_dma_if.master             mem
);
  state_t                state, state_n;
  mode_t                 mode_q;
  logic [ADDR_WIDTH-1:0] src_ptr, dst_ptr;
  logic [LEN_WIDTH-1:0]  remaining;
  logic [DATA_WIDTH-1:0] fill_q;
  logic                  accept;
  always_comb begin
    busy = state == RD || state == WR;
    done = state == DONE;
    accept = start && !busy;
    mem.mem_we = state == WR;
    mem.mem_addr = state == RD ? src_ptr : state == WR ? dst_ptr : '0;
    mem.mem_din = state == WR ? (mode_q == MODE_COPY ? mem.mem_dout : fill_q) : '0;
  end
  always_comb begin
    state_n = state;
    if (accept) state_n = len == '0 ? DONE : mode_t'(mode) == MODE_FILL ? WR : RD;
    else if (state == DONE) state_n = IDLE;
    else if (state == RD) state_n = WR;
    else if (state == WR) state_n = remaining == LEN_WIDTH'(1) ? DONE : mode_q == MODE_FILL ? WR : RD;
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      mode_q    <= MODE_COPY;
      src_ptr   <= '0;
      dst_ptr   <= '0;
      remaining <= '0;
      fill_q    <= '0;
    end else begin
      state <= state_n;
      if (accept) begin
        mode_q    <= mode_t'(mode);
        src_ptr   <= src_addr;
        dst_ptr   <= dst_addr;
        remaining <= len;
        fill_q    <= fill_value;
      end else if (state == WR) begin
        // pointers wrap naturally at the address width
        src_ptr   <= src_ptr + 1'b1;
        dst_ptr   <= dst_ptr + 1'b1;
        remaining <= remaining - 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_ram_dma.sv
// tb_ram_dma: directed self-checking bench for ram_dma with a behavioural single-port RAM
module tb_ram_dma;
  import ram_dma_pkg::*;
  logic        clk = 0;
  logic        reset_n = 0;
  logic        start = 0;
  logic        mode = 0;
  logic [15:0] src_addr = 0, dst_addr = 0, fill_value = 0;
  logic [16:0] len = 0;
  logic        busy, done;
  logic [15:0] ram [0:65535];
  int          tests = 0, fails = 0;
  int          we_cnt, done_cnt, cyc;
  logic        busy_seen;
  logic [15:0] wr_q [$];

  ram_dma_if #(.ADDR_WIDTH(16), .DATA_WIDTH(16)) mem ();

  ram_dma dut (
    .clk(clk), .reset_n(reset_n), .start(start), .mode(mode),
    .src_addr(src_addr), .dst_addr(dst_addr), .len(len), .fill_value(fill_value),
    .busy(busy), .done(done), .mem(mem)
  );

  always #5 clk = ~clk;

  // read-before-write single-port RAM with registered read
  always @(posedge clk) begin
    if (mem.mem_we) ram[mem.mem_addr] <= mem.mem_din;
    mem.mem_dout <= ram[mem.mem_addr];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk); #1;
    if (mem.mem_we) begin
      we_cnt++;
      wr_q.push_back(mem.mem_addr);
    end
    if (done) done_cnt++;
    if (busy) busy_seen = 1;
  endtask

  task automatic clear_stats();
    we_cnt = 0; done_cnt = 0; busy_seen = 0; wr_q.delete();
  endtask

  task automatic launch(input logic m, input logic [15:0] s, input logic [15:0] d,
                        input logic [16:0] l, input logic [15:0] f);
    mode = m; src_addr = s; dst_addr = d; len = l; fill_value = f;
    clear_stats();
    start = 1;
    step();
    start = 0;
    cyc = 1;
  endtask

  task automatic wait_done();
    while (!done && cyc < 200) begin
      step();
      cyc++;
    end
  endtask

  initial begin
    #2;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_we", mem.mem_we, 0);
    chk("rst_addr", mem.mem_addr, 0);
    chk("rst_din", mem.mem_din, 0);
    #10 reset_n = 1;

    // COPY len=3
    ram[16'h0010] = 16'hAAAA; ram[16'h0011] = 16'hBBBB; ram[16'h0012] = 16'hCCCC;
    ram[16'h0100] = 0; ram[16'h0101] = 0; ram[16'h0102] = 0;
    launch(1'b0, 16'h0010, 16'h0100, 17'd3, 16'h0);
    wait_done();
    chk("copy_cycles", cyc, 7);
    step();
    chk("copy_done_pulse", done_cnt, 1);
    chk("copy_done_low", done, 0);
    chk("copy_we_cnt", we_cnt, 3);
    chk("copy_wa0", wr_q[0], 16'h0100);
    chk("copy_wa1", wr_q[1], 16'h0101);
    chk("copy_wa2", wr_q[2], 16'h0102);
    chk("copy_d0", ram[16'h0100], 16'hAAAA);
    chk("copy_d1", ram[16'h0101], 16'hBBBB);
    chk("copy_d2", ram[16'h0102], 16'hCCCC);

    // FILL across address wrap
    launch(1'b1, 16'h0, 16'hFFFE, 17'd4, 16'hBEEF);
    wait_done();
    chk("fill_cycles", cyc, 5);
    chk("fill_we_cnt", we_cnt, 4);
    chk("fill_wa0", wr_q[0], 16'hFFFE);
    chk("fill_wa1", wr_q[1], 16'hFFFF);
    chk("fill_wa2", wr_q[2], 16'h0000);
    chk("fill_wa3", wr_q[3], 16'h0001);
    step();
    chk("fill_d_fffe", ram[16'hFFFE], 16'hBEEF);
    chk("fill_d_ffff", ram[16'hFFFF], 16'hBEEF);
    chk("fill_d_0000", ram[16'h0000], 16'hBEEF);
    chk("fill_d_0001", ram[16'h0001], 16'hBEEF);

    // len=0 in both modes
    for (int m = 0; m < 2; m++) begin
      launch(m[0], 16'h0300, 16'h0400, 17'd0, 16'h1234);
      wait_done();
      chk("len0_cycles", cyc, 1);
      step();
      chk("len0_we_cnt", we_cnt, 0);
      chk("len0_busy_seen", busy_seen, 0);
      chk("len0_done_pulse", done_cnt, 1);
    end

    // start pulsed while busy must be ignored
    for (int i = 0; i < 4; i++) begin
      ram[16'h0040 + i] = 16'h4000 + 16'(i);
      ram[16'h0080 + i] = 0;
    end
    launch(1'b0, 16'h0040, 16'h0080, 17'd4, 16'h0);
    step(); step(); cyc += 2;
    mode = 1; dst_addr = 16'h0500; len = 17'd1; start = 1;
    step(); cyc++;
    start = 0;
    wait_done();
    chk("busy_start_cycles", cyc, 9);
    step(); step(); step();
    chk("busy_start_done_cnt", done_cnt, 1);
    chk("busy_start_we_cnt", we_cnt, 4);
    for (int i = 0; i < 4; i++) chk("busy_start_data", ram[16'h0080 + i], 16'h4000 + 16'(i));

    // reset after the second write of a COPY
    for (int i = 0; i < 4; i++) begin
      ram[16'h0060 + i] = 16'h6000 + 16'(i);
      ram[16'h00C0 + i] = 0;
    end
    launch(1'b0, 16'h0060, 16'h00C0, 17'd4, 16'h0);
    step(); step(); step(); step();
    chk("abort_we_cnt", we_cnt, 2);
    chk("abort_busy_before", busy, 1);
    reset_n = 0;
    #1;
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_we", mem.mem_we, 0);
    chk("abort_addr", mem.mem_addr, 0);
    chk("abort_din", mem.mem_din, 0);
    step(); step();
    reset_n = 1;
    ram[16'h0200] = 0;
    launch(1'b1, 16'h0, 16'h0200, 17'd1, 16'h5A5A);
    wait_done();
    chk("post_fill_cycles", cyc, 2);
    step();
    chk("post_fill_data", ram[16'h0200], 16'h5A5A);
    chk("abort_w0", ram[16'h00C0], 16'h6000);
    chk("abort_w1", ram[16'h00C1], 16'h6001);
    chk("abort_w2", ram[16'h00C2], 16'h0000);
    chk("abort_w3", ram[16'h00C3], 16'h0000);

    // overlapping forward copy propagates the first word
    ram[16'h0020] = 16'h7777; ram[16'h0021] = 1; ram[16'h0022] = 2;
    ram[16'h0023] = 3; ram[16'h0024] = 4;
    launch(1'b0, 16'h0020, 16'h0021, 17'd3, 16'h0);
    wait_done();
    chk("ovl_cycles", cyc, 7);
    step();
    chk("ovl_d21", ram[16'h0021], 16'h7777);
    chk("ovl_d22", ram[16'h0022], 16'h7777);
    chk("ovl_d23", ram[16'h0023], 16'h7777);
    chk("ovl_d24", ram[16'h0024], 16'h0004);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
